// File: rtl/dram_readback_uart.sv
// Purpose: sweeps DPRA over LANES 32x1 RAM columns, captures DPO, streams the bits out as 8N1 UART bytes.
// Latency: SCAN takes 2*depth cycles; the first start bit follows at once, then bytes go back to back, CLK_DIV cycles per bit.
// Backpressure: none; start is ignored while busy (and on the cycle done pulses). Define DRAM_READBACK_HDR_EN to prepend a 0xA5 header byte.
module dram_readback_uart #(
  parameter int ADDR_W  = 5,
  parameter int LANES   = 2,
  parameter int CLK_DIV = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] dpra,
  input  logic [LANES-1:0]  dpo,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NDATA = LANES * DEPTH / 8;
`ifdef DRAM_READBACK_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NBYTES = NDATA + HDR;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BAUD_W = $clog2(CLK_DIV);

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE   = BYTE_W'(NBYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        STOP_BIT    = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;

  // Scan side: phase 0 = settle cycle, phase 1 = sample cycle.
  logic                     phase;
  logic [ADDR_W-1:0]        addr;
  // Lane k, address a lives at bit k*DEPTH + a, so overall byte b is cap[8b +: 8].
  logic [LANES*DEPTH-1:0]   cap;

  // UART side.
  logic [BAUD_W-1:0]        baud_cnt;
  logic [3:0]               bit_cnt;
  logic [BYTE_W-1:0]        byte_cnt;
  logic                     done_q;

  logic                     baud_tick;
  logic                     scan_last;
  logic                     send_last;
  logic [BYTE_W-1:0]        data_idx;
  logic [7:0]               cur_byte;
  logic                     tx_bit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and registered-state outputs.
  always_comb begin
    state_nxt = state;
    scan_last = 1'b0;
    send_last = 1'b0;
    baud_tick = (baud_cnt == '0);
    busy      = (state != IDLE);
    tx        = 1'b1;
    case (state)
      IDLE: begin
        // done_q high means busy just fell this cycle; such a start is dropped.
        if (start && !done_q) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        scan_last = phase && (addr == LAST_ADDR);
        if (scan_last) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        tx        = tx_bit;
        send_last = baud_tick && (bit_cnt == STOP_BIT) && (byte_cnt == LAST_BYTE);
        if (send_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign dpra = addr;
  assign done = done_q;

  // Address sweep: hold each address for a settle and a sample cycle; wraps to 0 after the last one.
  always_ff @(posedge clk) begin
    if (rst || state != SCAN) begin
      phase <= 1'b0;
      addr  <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  // Capture every lane's DPO bit on the sample cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap <= '0;
    end else if (state == SCAN && phase) begin
      for (int k = 0; k < LANES; k++) begin
        for (int a = 0; a < DEPTH; a++) begin
          if (addr == ADDR_W'(a)) begin
            cap[k*DEPTH + a] <= dpo[k];
          end
        end
      end
    end
  end

  // Baud, bit and byte counters; held at their start values outside SEND.
  always_ff @(posedge clk) begin
    if (rst || state != SEND) begin
      baud_cnt <= BAUD_RELOAD;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else if (baud_tick) begin
      baud_cnt <= BAUD_RELOAD;
      if (bit_cnt == STOP_BIT) begin
        bit_cnt  <= '0;
        byte_cnt <= send_last ? '0 : byte_cnt + BYTE_W'(1);
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt - BAUD_W'(1);
    end
  end

  // Completion pulse lands on the cycle the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= send_last;
    end
  end

  // Select the current byte and the serial bit within its frame.
  always_comb begin
`ifdef DRAM_READBACK_HDR_EN
    data_idx = byte_cnt - BYTE_W'(1);
`else
    data_idx = byte_cnt;
`endif
    cur_byte = '0;
    for (int b = 0; b < NDATA; b++) begin
      if (data_idx == BYTE_W'(b)) begin
        cur_byte = cap[8*b +: 8];
      end
    end
`ifdef DRAM_READBACK_HDR_EN
    if (byte_cnt == '0) begin
      cur_byte = 8'hA5;
    end
`endif
    case (bit_cnt)
      4'd0:    tx_bit = 1'b0;
      STOP_BIT: tx_bit = 1'b1;
      default: tx_bit = cur_byte[3'(bit_cnt - 4'd1)];
    endcase
  end

endmodule
